// File: rtl/dmem_pkg.sv
// dmem_pkg: shared constants for the data-memory responder.
//   - funct3 width codes (F3_B, F3_H, F3_W, F3_BU, F3_HU)
//   - responder FSM state encoding (IDLE / WAIT / RESP)
//   - width of the wait-state down-counter (WAIT_STATES is 0..15)
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int WCNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/dmem_lane_fmt.sv
// dmem_lane_fmt: combinational byte-lane formatter for the data-memory responder.
// Optional feature macro: DMEM_FAULT_CHECK_EN (misalignment / illegal-code fault detection).
// Ports:
//   funct3    in  3   width code (B, H, W, BU, HU)
//   we        in  1   1 = store, 0 = load
//   addr_lo   in  2   byte offset within the word
//   wdata     in  32  store data (rs2)
//   word      in  32  raw word read from the array
//   lane_en   out 4   per-byte write enables (all zero on fault)
//   wdata_rep out 32  store data replicated across lanes
//   rdata_ext out 32  selected and sign/zero-extended load data
//   fault     out 1   access rejected (always 0 without DMEM_FAULT_CHECK_EN)
module dmem_lane_fmt
    import dmem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic        we,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] word,
    output logic [3:0]  lane_en,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext,
    output logic        fault
);

    logic       is_b;
    logic       is_h;
    logic       is_w;
    logic       is_unsigned;
    logic       illegal;
    logic [1:0] lane_sel;
    logic [7:0] byte_sel;
    logic [15:0] half_sel;
    logic [7:0] word_bytes [4];

    always_comb begin
        is_b        = (funct3 == F3_B) || (funct3 == F3_BU);
        is_h        = (funct3 == F3_H) || (funct3 == F3_HU);
        illegal     = !(is_b || is_h || (funct3 == F3_W));
        // Anything that is not B/H behaves as a word access; with fault
        // checking enabled the illegal codes are rejected anyway.
        is_w        = !is_b && !is_h;
        is_unsigned = funct3[2];
        // Force alignment of the low bits; when fault checking is enabled a
        // misaligned access never reaches the array so this is harmless.
        lane_sel = addr_lo;
        if (is_w) begin
            lane_sel = 2'b00;
        end else if (is_h) begin
            lane_sel[0] = 1'b0;
        end
    end

`ifdef DMEM_FAULT_CHECK_EN
    assign fault = illegal
                || (is_h && addr_lo[0])
                || ((funct3 == F3_W) && (addr_lo != 2'b00))
                || (is_unsigned && we);
`else
    logic unused_fmt;
    assign fault      = 1'b0;
    assign unused_fmt = we ^ illegal;
`endif

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            assign word_bytes[gi] = word[8*gi +: 8];
            assign lane_en[gi]    = !fault && (is_w
                                    || (is_h && (lane_sel[1] == LANE[1]))
                                    || (is_b && (lane_sel == LANE)));
        end
    endgenerate

    assign byte_sel = word_bytes[lane_sel];
    assign half_sel = lane_sel[1] ? word[31:16] : word[15:0];

    always_comb begin
        rdata_ext = word;
        wdata_rep = wdata;
        if (is_b) begin
            rdata_ext = is_unsigned ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            wdata_rep = {4{wdata[7:0]}};
        end else if (is_h) begin
            rdata_ext = is_unsigned ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
            wdata_rep = {2{wdata[15:0]}};
        end
    end

endmodule

// File: rtl/dmem_resp.sv
// dmem_resp: data-memory responder for the RV32I load/store port.
// Accepts one request at a time, inserts WAIT_STATES wait cycles, performs
// byte/half/word stores with lane enables and returns extended load data.
// Optional feature macro: DMEM_FAULT_CHECK_EN (reject misaligned/illegal accesses).
// Parameters: DEPTH_WORDS (power of two, >= 4), WAIT_STATES (0..15).
// Ports:
//   dm_clk    in  1   rising-edge clock
//   dm_rst    in  1   asynchronous active-high reset
//   dm_req    in  1   request valid, held stable until dm_ready
//   dm_we     in  1   1 = store, 0 = load
//   dm_funct3 in  3   width code
//   dm_addr   in  32  byte address
//   dm_wdata  in  32  store data
//   dm_rdata  out 32  registered extended load data, held between responses
//   dm_ready  out 1   one-cycle response strobe
//   dm_fault  out 1   access rejected, valid with dm_ready
module dmem_resp
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic        dm_clk,
    input  logic        dm_rst,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [2:0]  dm_funct3,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic [31:0] dm_rdata,
    output logic        dm_ready,
    output logic        dm_fault
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [WCNT_W-1:0] CNT_LOAD =
        (WAIT_STATES > 0) ? WCNT_W'(WAIT_STATES - 1) : '0;

    state_t              state_reg;
    state_t              state_next;
    logic [WCNT_W-1:0]   cnt_reg;
    logic                we_reg;
    logic [2:0]          funct3_reg;
    logic [AW+1:0]       addr_reg;
    logic [31:0]         wdata_reg;
    logic                enter_resp;

    logic                cur_we;
    logic [2:0]          cur_funct3;
    logic [AW+1:0]       cur_addr;
    logic [31:0]         cur_wdata;
    logic [31:0]         word_raw;

    logic [3:0]          lane_en;
    logic [31:0]         wdata_rep;
    logic [31:0]         rdata_ext;
    logic                fmt_fault;

    logic [31:0]         mem [DEPTH_WORDS];

    logic                unused_addr;
    assign unused_addr = ^dm_addr[31:AW+2];

    // With zero wait states the array is accessed on the acceptance edge, so
    // the live request fields are used in IDLE; afterwards the captured ones.
    always_comb begin
        if (state_reg == IDLE) begin
            cur_we     = dm_we;
            cur_funct3 = dm_funct3;
            cur_addr   = dm_addr[AW+1:0];
            cur_wdata  = dm_wdata;
        end else begin
            cur_we     = we_reg;
            cur_funct3 = funct3_reg;
            cur_addr   = addr_reg;
            cur_wdata  = wdata_reg;
        end
    end

    assign word_raw = mem[cur_addr[AW+1:2]];

    dmem_lane_fmt u_fmt (
        .funct3    (cur_funct3),
        .we        (cur_we),
        .addr_lo   (cur_addr[1:0]),
        .wdata     (cur_wdata),
        .word      (word_raw),
        .lane_en   (lane_en),
        .wdata_rep (wdata_rep),
        .rdata_ext (rdata_ext),
        .fault     (fmt_fault)
    );

    // Next-state and output decode.
    always_comb begin
        state_next = state_reg;
        dm_ready   = 1'b0;
        enter_resp = 1'b0;
        case (state_reg)
            IDLE: begin
                if (dm_req) begin
                    if (WAIT_STATES > 0) begin
                        state_next = WAIT;
                    end else begin
                        state_next = RESP;
                        enter_resp = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (cnt_reg == '0) begin
                    state_next = RESP;
                    enter_resp = 1'b1;
                end
            end
            RESP: begin
                dm_ready   = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge dm_clk or posedge dm_rst) begin
        if (dm_rst) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            we_reg     <= 1'b0;
            funct3_reg <= 3'b000;
            addr_reg   <= '0;
            wdata_reg  <= 32'b0;
            dm_rdata   <= 32'b0;
            dm_fault   <= 1'b0;
        end else begin
            state_reg <= state_next;
            if ((state_reg == IDLE) && dm_req) begin
                we_reg     <= dm_we;
                funct3_reg <= dm_funct3;
                addr_reg   <= dm_addr[AW+1:0];
                wdata_reg  <= dm_wdata;
                cnt_reg    <= CNT_LOAD;
            end else if ((state_reg == WAIT) && (cnt_reg != '0)) begin
                cnt_reg <= cnt_reg - 1'b1;
            end
            if (enter_resp) begin
                dm_fault <= fmt_fault;
                if (fmt_fault) begin
                    dm_rdata <= 32'b0;
                end else if (!cur_we) begin
                    dm_rdata <= rdata_ext;
                end
            end
        end
    end

    // Array contents are never reset; lane enables are already zero on fault.
    always_ff @(posedge dm_clk) begin
        if (enter_resp && cur_we) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_en[i]) begin
                    mem[cur_addr[AW+1:2]][8*i +: 8] <= wdata_rep[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: doc/dmem_resp.md
# dmem_resp

Data-memory responder serving the load/store port of the RV32I core datapath. It accepts one request at a time over a req/ready handshake and inserts a configurable number of wait states. It performs byte, halfword and word stores with lane enables, and returns sign- or zero-extended load data. It sits between the datapath's ALU-address and rs2-data outputs and the write-back mux's memory input.

## Interface
- DEPTH_WORDS, 1024: number of 32-bit words; power of two, at least 4.
- WAIT_STATES, 1: cycles inserted between acceptance and response; range 0..15.
- dm_clk  in  1  rising-edge clock.
- dm_rst  in  1  asynchronous, active-high reset.
- dm_req  in  1  request valid; held with all fields stable until dm_ready.
- dm_we  in  1  1 = store, 0 = load.
- dm_funct3  in  3  width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- dm_addr  in  32  byte address (ALU result).
- dm_wdata  in  32  store data (rs2); low byte or halfword is used for B/H.
- dm_rdata  out  32  extended load data; registered; held until the next response.
- dm_ready  out  1  one-cycle response strobe.
- dm_fault  out  1  valid with dm_ready; the access was rejected.

Clock and reset: one clock, dm_clk. Reset dm_rst is asynchronous and active-high.

## Operation
- FSM states and transitions:
  - IDLE: dm_req=1 captures we/funct3/addr/wdata. Goes to WAIT if WAIT_STATES>0, else to RESP.
  - WAIT: down-counter loaded with WAIT_STATES-1. Goes to RESP when the counter is 0.
  - RESP: dm_ready=1 for exactly one cycle, then IDLE. A request present in RESP is not accepted; acceptance happens earliest in the following IDLE cycle.
- Word index is addr[log2(DEPTH_WORDS)+1:2]. Upper address bits are ignored, so addresses alias (wrap-around) modulo 4*DEPTH_WORDS.
- Store lane enables:
  - B: the single lane addr[1:0], carrying wdata[7:0].
  - H: lanes {addr[1],0} and {addr[1],1}, carrying wdata[15:0].
  - W: all four lanes.
  - Disabled lanes are unchanged.
- Load byte/half selection follows the same lanes. B/H are sign-extended from bit 7/15; BU/HU are zero-extended. W is passed through.
- A store has dm_rdata unchanged.
- Fault (macro enabled only) occurs on any of:
  - H/HU with addr[0]=1;
  - W with addr[1:0]≠0;
  - funct3 ∈ {011,110,111};
  - BU/HU with dm_we=1.
- On a fault: no array write, dm_rdata=0, dm_fault=1 in RESP.
- Memory contents are not reset; the array is uninitialised at start.

## Timing
- Reset values: state IDLE, dm_rdata=0, dm_ready=0, dm_fault=0, counter=0.
- Acceptance is at the edge ending cycle 0, the IDLE cycle with dm_req=1. dm_ready is high in cycle WAIT_STATES+1.
- Array write and dm_rdata update both occur on the edge entering RESP.
- A load in the transaction immediately following a store to the same word returns the new data.
- dm_fault is registered with dm_rdata and cleared on the next RESP without fault.
- Back-to-back throughput: one transaction per WAIT_STATES+2 cycles.
- Reset asserted in WAIT: return to IDLE with no write committed. Reset asserted in RESP: dm_ready drops immediately; the write has already committed.
- dm_req deasserted mid-transaction is a protocol violation. The transaction still completes on the captured fields.

## Configuration
- DMEM_FAULT_CHECK_EN defined: fault detection as in Operation.
- Not defined:
  - dm_fault is tied to 0.
  - Low address bits are forced aligned: W ignores addr[1:0], H/HU ignore addr[0].
  - Illegal funct3 is treated as W.

## Structure
- Package dmem_pkg holds:
  - funct3 localparams F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - state enum IDLE/WAIT/RESP;
  - the wait-counter width constant.
- Sub-module dmem_lane_fmt (combinational) takes funct3, addr[1:0], wdata and the raw word. It produces the 4-bit lane enable, the replicated store data, the extended load data and the fault flag.
- The FSM and the array are in dmem_resp itself.

## Test plan
- Reset, then SW 0xDEADBEEF to 0x100, then LW 0x100 with WAIT_STATES=1. Each dm_ready appears in the 2nd cycle after acceptance; rdata=0xDEADBEEF, fault=0.
- LB 0x103 gives 0xFFFFFFDE; LBU 0x103 gives 0x000000DE; LH 0x102 gives 0xFFFFDEAD; LHU 0x100 gives 0x0000BEEF.
- SB 0x55 to 0x101, then LW 0x100 gives 0xDEAD55EF. SH 0x1234 to 0x102, then LW gives 0x123455EF.
- With the macro: LW 0x101 and SH 0x103 each give fault=1, rdata=0, and memory unchanged. Without the macro: LW 0x101 returns the word at 0x100.
- Aliasing with DEPTH_WORDS=1024: SW 0xA5A5A5A5 to 0x1000, then LW 0x0000 gives 0xA5A5A5A5.
- Reset pulse during WAIT of SW 0x11111111 to 0x200: no dm_ready; the next LW 0x200 returns the prior contents. With WAIT_STATES=0, back-to-back requests give dm_ready every 2nd cycle.
